// File: rtl/hamming_pair_sequencer.sv
// Walks every unordered word pair in data memory, tracks min/max Hamming distance, writes results back.
// Optional HAM_PAIR_ADDR_EN: also tracks and writes the (j,k) indices of the min and max pairs.
module hamming_pair_sequencer #(
    parameter int unsigned NUM_WORDS = 32,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned RES_ADDR  = 64,
    parameter int unsigned AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    output logic [4:0]    min_dist,
    output logic [4:0]    max_dist
`ifdef HAM_PAIR_ADDR_EN
    ,
    output logic [9:0]    min_pair,
    output logic [9:0]    max_pair
`endif
);

    localparam int unsigned JW = 5;
    localparam int unsigned KW = 6;
    localparam int unsigned DW = 5;

    typedef enum logic [3:0] {
        S_WAIT_HI, S_ARMED, S_LJ0, S_LJ1, S_LJ2, S_RK0, S_RK1, S_RK2, S_CMP,
        S_WR_MIN, S_WR_MAX,
`ifdef HAM_PAIR_ADDR_EN
        S_WR_MINJ, S_WR_MINK, S_WR_MAXJ, S_WR_MAXK,
`endif
        S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [JW-1:0]   r_j, w_j_nxt;
    logic [KW-1:0]   r_k, w_k_nxt;
    logic [15:0]     r_wj, r_wk;
    logic [DW-1:0]   r_min, r_max, w_min_nxt, w_max_nxt;
    logic [DW-1:0]   w_dist;
    logic [15:0]     w_xor;
    logic            w_k_more, w_j_more;
    logic            r_done, r_busy, r_rd_en, r_wr_en;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_wdata;
    logic            w_done, w_busy, w_rd_en, w_wr_en;
    logic [AW-1:0]   w_addr;
    logic [7:0]      w_wdata;
`ifdef HAM_PAIR_ADDR_EN
    logic [JW-1:0]   r_min_j, r_min_k, r_max_j, r_max_k;
    logic [JW-1:0]   w_min_j_nxt, w_min_k_nxt, w_max_j_nxt, w_max_k_nxt;
`endif

    assign w_xor    = r_wj ^ r_wk;
    assign w_k_more = r_k < KW'(NUM_WORDS - 1);
    assign w_j_more = r_j < JW'(NUM_WORDS - 2);

    always_comb begin
        w_dist = '0;
        for (int i = 0; i < 16; i++) w_dist = w_dist + DW'(w_xor[i]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_WAIT_HI;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_HI: if (start)  w_state_nxt = S_ARMED;
            S_ARMED:   if (!start) w_state_nxt = S_LJ0;
            S_LJ0:     w_state_nxt = S_LJ1;
            S_LJ1:     w_state_nxt = S_LJ2;
            S_LJ2:     w_state_nxt = S_RK0;
            S_RK0:     w_state_nxt = S_RK1;
            S_RK1:     w_state_nxt = S_RK2;
            S_RK2:     w_state_nxt = S_CMP;
            S_CMP: begin
                if (w_k_more)      w_state_nxt = S_RK0;
                else if (w_j_more) w_state_nxt = S_LJ0;
                else               w_state_nxt = S_WR_MIN;
            end
            S_WR_MIN:  w_state_nxt = S_WR_MAX;
`ifdef HAM_PAIR_ADDR_EN
            S_WR_MAX:  w_state_nxt = S_WR_MINJ;
            S_WR_MINJ: w_state_nxt = S_WR_MINK;
            S_WR_MINK: w_state_nxt = S_WR_MAXJ;
            S_WR_MAXJ: w_state_nxt = S_WR_MAXK;
            S_WR_MAXK: w_state_nxt = S_DONE;
`else
            S_WR_MAX:  w_state_nxt = S_DONE;
`endif
            S_DONE:    if (start) w_state_nxt = S_ARMED;
            default:   w_state_nxt = S_WAIT_HI;
        endcase
    end

    // Loop counters and running min/max; strict compares keep the earliest pair on ties
    always_comb begin
        w_j_nxt   = r_j;
        w_k_nxt   = r_k;
        w_min_nxt = r_min;
        w_max_nxt = r_max;
`ifdef HAM_PAIR_ADDR_EN
        w_min_j_nxt = r_min_j;
        w_min_k_nxt = r_min_k;
        w_max_j_nxt = r_max_j;
        w_max_k_nxt = r_max_k;
`endif
        case (r_state)
            S_ARMED: if (!start) begin
                w_j_nxt   = '0;
                w_min_nxt = DW'(16);
                w_max_nxt = '0;
`ifdef HAM_PAIR_ADDR_EN
                w_min_j_nxt = '0;
                w_min_k_nxt = JW'(1);
                w_max_j_nxt = '0;
                w_max_k_nxt = JW'(1);
`endif
            end
            S_LJ2: w_k_nxt = KW'(r_j) + KW'(1);
            S_CMP: begin
                if (w_dist < r_min) begin
                    w_min_nxt = w_dist;
`ifdef HAM_PAIR_ADDR_EN
                    w_min_j_nxt = r_j;
                    w_min_k_nxt = r_k[JW-1:0];
`endif
                end
                if (w_dist > r_max) begin
                    w_max_nxt = w_dist;
`ifdef HAM_PAIR_ADDR_EN
                    w_max_j_nxt = r_j;
                    w_max_k_nxt = r_k[JW-1:0];
`endif
                end
                if (w_k_more)      w_k_nxt = r_k + KW'(1);
                else if (w_j_more) w_j_nxt = r_j + JW'(1);
            end
            default: ;
        endcase
    end

    // Output decode from the upcoming state so registered strobes line up with it
    always_comb begin
        w_done  = 1'b0;
        w_busy  = 1'b0;
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (w_state_nxt)
            S_LJ0: begin
                w_busy = 1'b1; w_rd_en = 1'b1;
                w_addr = AW'(BASE_ADDR) + AW'({w_j_nxt, 1'b0});
            end
            S_LJ1: begin
                w_busy = 1'b1; w_rd_en = 1'b1;
                w_addr = AW'(BASE_ADDR) + AW'({w_j_nxt, 1'b1});
            end
            S_RK0: begin
                w_busy = 1'b1; w_rd_en = 1'b1;
                w_addr = AW'(BASE_ADDR) + AW'({w_k_nxt[JW-1:0], 1'b0});
            end
            S_RK1: begin
                w_busy = 1'b1; w_rd_en = 1'b1;
                w_addr = AW'(BASE_ADDR) + AW'({w_k_nxt[JW-1:0], 1'b1});
            end
            S_LJ2, S_RK2, S_CMP: w_busy = 1'b1;
            S_WR_MIN: begin
                w_busy = 1'b1; w_wr_en = 1'b1;
                w_addr = AW'(RES_ADDR); w_wdata = 8'(w_min_nxt);
            end
            S_WR_MAX: begin
                w_busy = 1'b1; w_wr_en = 1'b1;
                w_addr = AW'(RES_ADDR + 1); w_wdata = 8'(w_max_nxt);
            end
`ifdef HAM_PAIR_ADDR_EN
            S_WR_MINJ: begin
                w_busy = 1'b1; w_wr_en = 1'b1;
                w_addr = AW'(RES_ADDR + 2); w_wdata = 8'(w_min_j_nxt);
            end
            S_WR_MINK: begin
                w_busy = 1'b1; w_wr_en = 1'b1;
                w_addr = AW'(RES_ADDR + 3); w_wdata = 8'(w_min_k_nxt);
            end
            S_WR_MAXJ: begin
                w_busy = 1'b1; w_wr_en = 1'b1;
                w_addr = AW'(RES_ADDR + 4); w_wdata = 8'(w_max_j_nxt);
            end
            S_WR_MAXK: begin
                w_busy = 1'b1; w_wr_en = 1'b1;
                w_addr = AW'(RES_ADDR + 5); w_wdata = 8'(w_max_k_nxt);
            end
`endif
            S_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers; read data arrives the cycle after its strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_j     <= '0;
            r_k     <= '0;
            r_wj    <= '0;
            r_wk    <= '0;
            r_min   <= DW'(16);
            r_max   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
`ifdef HAM_PAIR_ADDR_EN
            r_min_j <= '0;
            r_min_k <= JW'(1);
            r_max_j <= '0;
            r_max_k <= JW'(1);
`endif
        end else begin
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_min   <= w_min_nxt;
            r_max   <= w_max_nxt;
            r_done  <= w_done;
            r_busy  <= w_busy;
            r_rd_en <= w_rd_en;
            r_wr_en <= w_wr_en;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
`ifdef HAM_PAIR_ADDR_EN
            r_min_j <= w_min_j_nxt;
            r_min_k <= w_min_k_nxt;
            r_max_j <= w_max_j_nxt;
            r_max_k <= w_max_k_nxt;
`endif
            case (r_state)
                S_LJ1:   r_wj[15:8] <= mem_rdata;
                S_LJ2:   r_wj[7:0]  <= mem_rdata;
                S_RK1:   r_wk[15:8] <= mem_rdata;
                S_RK2:   r_wk[7:0]  <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign done      = r_done;
    assign busy      = r_busy;
    assign mem_addr  = r_addr;
    assign mem_rd_en = r_rd_en;
    assign mem_wr_en = r_wr_en;
    assign mem_wdata = r_wdata;
    assign min_dist  = r_min;
    assign max_dist  = r_max;
`ifdef HAM_PAIR_ADDR_EN
    assign min_pair  = {r_min_k, r_min_j};
    assign max_pair  = {r_max_k, r_max_j};
`endif

endmodule
